// File: rtl/cam_i2c_pkg.sv
// Shared types and constants for the camera I2C write arbiter and its users.
package cam_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_HIGH = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  typedef enum logic {
    REQ_CFG = 1'b0,
    REQ_RT  = 1'b1
  } req_id_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CFG  = 2'b01;
  localparam logic [1:0] GRANT_RT   = 2'b10;

  // Camera SCCB device address, shared with cam_config.
  localparam logic [7:0] CAM_I2C_ADDR = 8'h42;

  function automatic logic [1:0] grant_of(input req_id_e id);
    return (id == REQ_CFG) ? GRANT_CFG : GRANT_RT;
  endfunction

endpackage

// File: rtl/cam_i2c_wdt.sv
// Saturating cycle counter with two selectable limits; expire marks the last allowed cycle.
module cam_i2c_wdt #(
  parameter int unsigned SHORT_LIMIT = 8,
  parameter int unsigned LONG_LIMIT  = 16384
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_sel_long,
  output logic o_expire
);

  localparam int unsigned CW = $clog2(LONG_LIMIT + 1);
  localparam logic [CW-1:0] SHORT_LAST = CW'(SHORT_LIMIT - 1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = (cnt_q >= (i_sel_long ? LONG_LAST : SHORT_LAST));

endmodule

// File: rtl/cam_i2c_arbiter.sv
// Two-requester arbiter in front of the camera I2C write master: one latched write per grant,
// start pulse, busy/idle tracking with watchdog, ack (and error) back to the owner.
module cam_i2c_arbiter
  import cam_i2c_pkg::*;
#(
  parameter int unsigned BUSY_WAIT_CYCLES = 8,
  parameter int unsigned TIMEOUT_CYCLES   = 16384
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cfg_req,
  input  logic [7:0] i_cfg_addr,
  input  logic [7:0] i_cfg_data,
  input  logic       i_cfg_active,
  output logic       o_cfg_ack,
  input  logic       i_rt_req,
  input  logic [7:0] i_rt_addr,
  input  logic [7:0] i_rt_data,
  output logic       o_rt_ack,
  output logic       o_i2c_start,
  output logic [7:0] o_i2c_addr,
  output logic [7:0] o_i2c_data,
  input  logic       i_i2c_ready,
  output logic [1:0] o_grant,
  output logic       o_err,
  output logic       o_timeout_flag
);

  state_e     state_q, state_d;
  req_id_e    owner_q, owner_d;
  req_id_e    rr_q, rr_d;
  logic       contend_q, contend_d;
  logic [1:0] grant_q, grant_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       err_q, err_d;
  logic       flag_q, flag_d;

  logic    cfg_elig, rt_elig;
  req_id_e pick;
  logic    wdt_clr, wdt_en, wdt_long, wdt_expire;

  assign cfg_elig = i_cfg_req;
  assign rt_elig  = i_rt_req && !i_cfg_active;

  cam_i2c_wdt #(
    .SHORT_LIMIT(BUSY_WAIT_CYCLES),
    .LONG_LIMIT (TIMEOUT_CYCLES)
  ) u_wdt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (wdt_clr),
    .i_en      (wdt_en),
    .i_sel_long(wdt_long),
    .o_expire  (wdt_expire)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    contend_d = contend_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = err_q;
    flag_d    = flag_q;
    wdt_clr   = 1'b0;
    wdt_en    = 1'b0;
    wdt_long  = 1'b0;
    pick      = REQ_CFG;

    // Round-robin pointer remembers the winner of the last contended grant only, so an
    // uncontested grant does not disturb fairness between simultaneous requesters.
    if (cfg_elig && rt_elig) begin
      pick = (rr_q == REQ_RT) ? REQ_CFG : REQ_RT;
    end else if (rt_elig) begin
      pick = REQ_RT;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_i2c_ready && (cfg_elig || rt_elig)) begin
          owner_d   = pick;
          contend_d = cfg_elig && rt_elig;
          grant_d   = grant_of(pick);
          addr_d    = (pick == REQ_CFG) ? i_cfg_addr : i_rt_addr;
          data_d    = (pick == REQ_CFG) ? i_cfg_data : i_rt_data;
          err_d     = 1'b0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdt_clr = 1'b1;
        state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        wdt_en = 1'b1;
        if (!i_i2c_ready) begin
          wdt_clr = 1'b1;
          state_d = ST_WAIT_HIGH;
        end else if (wdt_expire) begin
          err_d   = 1'b1;
          flag_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WAIT_HIGH: begin
        wdt_en   = 1'b1;
        wdt_long = 1'b1;
        if (i_i2c_ready) begin
          state_d = ST_DONE;
        end else if (wdt_expire) begin
          err_d   = 1'b1;
          flag_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (contend_q) begin
          rr_d = owner_q;
        end
        grant_d = GRANT_NONE;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = GRANT_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= REQ_CFG;
      rr_q      <= REQ_RT;
      contend_q <= 1'b0;
      grant_q   <= GRANT_NONE;
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      contend_q <= contend_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      err_q     <= err_d;
      flag_q    <= flag_d;
    end
  end

  assign o_i2c_start    = (state_q == ST_ISSUE);
  assign o_cfg_ack      = (state_q == ST_DONE) && (owner_q == REQ_CFG);
  assign o_rt_ack       = (state_q == ST_DONE) && (owner_q == REQ_RT);
  assign o_err          = (state_q == ST_DONE) && err_q;
  assign o_grant        = grant_q;
  assign o_i2c_addr     = addr_q;
  assign o_i2c_data     = data_q;
  assign o_timeout_flag = flag_q;

endmodule

// File: tb/tb_cam_i2c_arbiter.sv
// Scoreboard bench for cam_i2c_arbiter with a behavioural I2C master ready model.
module tb_cam_i2c_arbiter;

  localparam int M_NORMAL     = 0;
  localparam int M_STUCK_HIGH = 1;
  localparam int M_STUCK_LOW  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_req, cfg_active, rt_req;
  logic [7:0] cfg_addr, cfg_data, rt_addr, rt_data;
  logic       cfg_ack, rt_ack, i2c_start, err, tflag;
  logic [7:0] i2c_addr, i2c_data;
  logic [1:0] grant;
  logic       i2c_ready = 1'b1;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          mode = M_NORMAL;
  int          phase = 0;
  int          pcnt = 0;
  int unsigned start_cyc = 0, drop_cyc = 0, rise_cyc = 0;
  int          n_starts = 0;

  typedef struct {
    logic [1:0] grant;
    logic [7:0] addr;
    logic [7:0] data;
  } start_t;

  typedef struct {
    logic [1:0] who;
    logic       err;
  } ack_t;

  start_t exp_start[$];
  ack_t   exp_ack[$];
  start_t s_m;
  ack_t   a_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cam_i2c_arbiter #(
    .BUSY_WAIT_CYCLES(8),
    .TIMEOUT_CYCLES  (64)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cfg_req     (cfg_req),
    .i_cfg_addr    (cfg_addr),
    .i_cfg_data    (cfg_data),
    .i_cfg_active  (cfg_active),
    .o_cfg_ack     (cfg_ack),
    .i_rt_req      (rt_req),
    .i_rt_addr     (rt_addr),
    .i_rt_data     (rt_data),
    .o_rt_ack      (rt_ack),
    .o_i2c_start   (i2c_start),
    .o_i2c_addr    (i2c_addr),
    .o_i2c_data    (i2c_data),
    .i_i2c_ready   (i2c_ready),
    .o_grant       (grant),
    .o_err         (err),
    .o_timeout_flag(tflag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Master model: ready drops 5 cycles after start, stays low 3 cycles.
  always @(negedge clk) begin
    if (i2c_start) begin
      phase = 1;
      pcnt = 0;
      start_cyc = cyc;
      n_starts++;
    end else if (phase == 1) begin
      pcnt++;
      if (mode != M_STUCK_HIGH && pcnt == 5) begin
        i2c_ready = 1'b0;
        drop_cyc = cyc;
        phase = 2;
        pcnt = 0;
      end
    end else if (phase == 2) begin
      pcnt++;
      if (mode != M_STUCK_LOW && pcnt >= 3) begin
        i2c_ready = 1'b1;
        rise_cyc = cyc;
        phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (i2c_start) begin
        if (exp_start.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got addr %0h data %0h grant %0b, expected none",
                   i2c_addr, i2c_data, grant);
        end else begin
          s_m = exp_start.pop_front();
          check("start_grant", 32'(grant), 32'(s_m.grant));
          check("start_addr", 32'(i2c_addr), 32'(s_m.addr));
          check("start_data", 32'(i2c_data), 32'(s_m.data));
        end
      end
      if (cfg_ack || rt_ack) begin
        if (exp_ack.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack %0b, expected none", {rt_ack, cfg_ack});
        end else begin
          a_m = exp_ack.pop_front();
          check("ack_who", 32'({rt_ack, cfg_ack}), 32'(a_m.who));
          check("ack_err", 32'(err), 32'(a_m.err));
          if (!a_m.err) check("ack_latency", cyc - rise_cyc, 32'd1);
        end
      end else if (err) begin
        checks++;
        errors++;
        $display("FAIL err_without_ack: got err 1, expected 0");
      end
    end
  end

  task automatic push_start(input logic [1:0] g, input logic [7:0] a, input logic [7:0] d);
    start_t s;
    s.grant = g; s.addr = a; s.data = d;
    exp_start.push_back(s);
  endtask

  task automatic push_ack(input logic [1:0] w, input logic e);
    ack_t a;
    a.who = w; a.err = e;
    exp_ack.push_back(a);
  endtask

  task automatic cfg_go(input logic [7:0] a, input logic [7:0] d);
    cfg_addr = a; cfg_data = d; cfg_req = 1'b1;
  endtask

  task automatic rt_go(input logic [7:0] a, input logic [7:0] d);
    rt_addr = a; rt_data = d; rt_req = 1'b1;
  endtask

  task automatic wait_acks(input bit wc, input bit wr, input int budget, input string name);
    bit gc = !wc;
    bit gr = !wr;
    int n = 0;
    while (!(gc && gr) && n < budget) begin
      @(negedge clk);
      n++;
      if (cfg_ack) begin gc = 1'b1; cfg_req = 1'b0; end
      if (rt_ack)  begin gr = 1'b1; rt_req  = 1'b0; end
    end
    checks++;
    if (!(gc && gr)) begin
      errors++;
      $display("FAIL %s_ack_wait: got cfg_done %0d rt_done %0d, expected both done", name, gc, gr);
      cfg_req = 1'b0;
      rt_req = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int ns0;
    rst = 1'b1;
    cfg_req = 0; cfg_active = 0; rt_req = 0;
    cfg_addr = 0; cfg_data = 0; rt_addr = 0; rt_data = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({grant, i2c_start, cfg_ack, rt_ack, err, tflag, i2c_addr, i2c_data}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single CFG write
    push_start(2'b01, 8'h12, 8'h80);
    push_ack(2'b01, 1'b0);
    cfg_go(8'h12, 8'h80);
    @(negedge clk);
    check("t1_start_latency", 32'(i2c_start), 32'd1);
    check("t1_grant", 32'(grant), 32'b01);
    wait_acks(1, 0, 40, "t1");
    @(negedge clk);
    check("t1_grant_cleared", 32'(grant), 32'd0);

    // 2: simultaneous requests, round-robin after reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_start(2'b01, 8'h11, 8'h01);
    push_start(2'b10, 8'h55, 8'h40);
    push_ack(2'b01, 1'b0);
    push_ack(2'b10, 1'b0);
    cfg_go(8'h11, 8'h01);
    rt_go(8'h55, 8'h40);
    wait_acks(1, 1, 80, "t2a");
    @(negedge clk);
    push_start(2'b10, 8'h56, 8'h41);
    push_start(2'b01, 8'h13, 8'h02);
    push_ack(2'b10, 1'b0);
    push_ack(2'b01, 1'b0);
    cfg_go(8'h13, 8'h02);
    rt_go(8'h56, 8'h41);
    wait_acks(1, 1, 80, "t2b");
    @(negedge clk);

    // 3: cfg_active blocks RT across three CFG writes
    cfg_active = 1'b1;
    rt_go(8'h66, 8'h77);
    for (int i = 0; i < 3; i++) begin
      push_start(2'b01, 8'(8'h20 + i), 8'(8'h30 + i));
      push_ack(2'b01, 1'b0);
      cfg_go(8'(8'h20 + i), 8'(8'h30 + i));
      wait_acks(1, 0, 40, "t3_cfg");
      @(negedge clk);
    end
    push_start(2'b10, 8'h66, 8'h77);
    push_ack(2'b10, 1'b0);
    cfg_active = 1'b0;
    n = 0;
    while (grant != 2'b10 && n < 2) begin
      @(negedge clk);
      n++;
    end
    check("t3_rt_grant_within_2", 32'(grant), 32'b10);
    wait_acks(0, 1, 40, "t3_rt");
    @(negedge clk);

    // 4: ready never drops -> busy-wait error
    mode = M_STUCK_HIGH;
    push_start(2'b01, 8'h2A, 8'h5A);
    push_ack(2'b01, 1'b1);
    cfg_go(8'h2A, 8'h5A);
    wait_acks(1, 0, 40, "t4");
    check("t4_wait_low_cycles", cyc - start_cyc, 32'd9);
    check("t4_flag_set", 32'(tflag), 32'd1);
    mode = M_NORMAL;
    @(negedge clk);
    push_start(2'b01, 8'h2B, 8'h5B);
    push_ack(2'b01, 1'b0);
    cfg_go(8'h2B, 8'h5B);
    wait_acks(1, 0, 40, "t4_next");
    check("t4_flag_sticky", 32'(tflag), 32'd1);
    @(negedge clk);

    // 5: ready stuck low -> timeout after 64 WAIT_HIGH cycles
    mode = M_STUCK_LOW;
    push_start(2'b01, 8'h3C, 8'hC3);
    push_ack(2'b01, 1'b1);
    cfg_go(8'h3C, 8'hC3);
    wait_acks(1, 0, 200, "t5");
    check("t5_wait_high_cycles", cyc - drop_cyc, 32'd65);
    @(negedge clk);
    check("t5_grant_cleared", 32'(grant), 32'd0);
    mode = M_NORMAL;
    repeat (2) @(negedge clk);

    // 6: reset while master busy; reissue only once ready returns
    mode = M_STUCK_LOW;
    push_start(2'b01, 8'h33, 8'h44);
    push_start(2'b01, 8'h33, 8'h44);
    push_ack(2'b01, 1'b0);
    cfg_go(8'h33, 8'h44);
    n = 0;
    while (i2c_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("t6_ready_dropped", 32'(i2c_ready), 32'd0);
    repeat (2) @(negedge clk);
    check("t6_grant_before_reset", 32'(grant), 32'b01);
    #2 rst = 1'b1;
    #1 check("t6_async_reset_outputs", 32'({grant, tflag, i2c_addr, i2c_data}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ns0 = n_starts;
    repeat (10) @(negedge clk);
    check("t6_no_start_while_busy", 32'(n_starts - ns0), 32'd0);
    mode = M_NORMAL;
    wait_acks(1, 0, 40, "t6");
    check("t6_single_reissue", 32'(n_starts - ns0), 32'd1);
    check("t6_flag_cleared", 32'(tflag), 32'd0);
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 32'(exp_start.size() + exp_ack.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
